// File: rtl/frac_freqdiv_prog.sv
// rtl/frac_freqdiv_prog.sv - programmable dual-modulus fractional clock divider
// Ratios are loaded via LOAD/ACK, divided serially, and applied at a period boundary.
module frac_freqdiv_prog #(
    parameter int WIDTH = 8
) (
    input  logic             CLK_in,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] NUM,
    input  logic [WIDTH-1:0] DEN,
    output logic             ACK,
    output logic             BUSY,
    output logic             CFG_ERR,
    output logic             ACTIVE,
    output logic             CLK_out,
    output logic             PULSE
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, CHECK, PENDING} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    div_cnt;
    logic [WIDTH-1:0] quo, rem, den_s;
    logic [WIDTH-1:0] n_live, x_live, den_live;
    logic [WIDTH-1:0] cnt, per, acc;

    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;
    logic             cfg_valid;
    logic             accept, div_step, cfg_bad, apply_now, boundary_run, boundary;
    logic [WIDTH-1:0] n_use, x_use, d_use, a_use, per_nxt, acc_nxt;
    logic [WIDTH:0]   sum;
    logic             clk_nxt;

    // Restoring division: quo starts as the dividend and fills with quotient bits.
    always_comb begin
        rem_sh    = {rem, quo[WIDTH-1]};
        rem_ge    = rem_sh >= {1'b0, den_s};
        rem_sub   = rem_sh[WIDTH-1:0] - den_s;
        cfg_valid = (den_s != '0) && (quo >= WIDTH'(2));
    end

    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        div_step     = 1'b0;
        cfg_bad      = 1'b0;
        apply_now    = 1'b0;
        BUSY         = (state != IDLE);
        boundary_run = ACTIVE && EN && (cnt == per - WIDTH'(1));
        case (state)
            IDLE: begin
                if (LOAD) begin
                    accept    = 1'b1;
                    state_nxt = DIVIDE;
                end
            end
            DIVIDE: begin
                div_step = 1'b1;
                if (div_cnt == CW'(WIDTH - 1)) state_nxt = CHECK;
            end
            CHECK: begin
                if (!cfg_valid) begin
                    cfg_bad   = 1'b1;
                    state_nxt = IDLE;
                end else if (!ACTIVE) begin
                    apply_now = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (boundary_run) begin
                    apply_now = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next period length from the remainder accumulator; a fresh config starts at acc=0.
    always_comb begin
        boundary = apply_now || boundary_run;
        n_use    = apply_now ? quo   : n_live;
        x_use    = apply_now ? rem   : x_live;
        d_use    = apply_now ? den_s : den_live;
        a_use    = apply_now ? '0    : acc;
        sum      = {1'b0, a_use} + {1'b0, x_use};
        if (sum >= {1'b0, d_use}) begin
            per_nxt = n_use + WIDTH'(1);
            acc_nxt = sum[WIDTH-1:0] - d_use;
        end else begin
            per_nxt = n_use;
            acc_nxt = sum[WIDTH-1:0];
        end
        clk_nxt = (cnt + WIDTH'(1)) < (per >> 1);
    end

    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            div_cnt  <= '0;
            quo      <= '0;
            rem      <= '0;
            den_s    <= '0;
            n_live   <= '0;
            x_live   <= '0;
            den_live <= '0;
            cnt      <= '0;
            per      <= '0;
            acc      <= '0;
            ACK      <= 1'b0;
            CFG_ERR  <= 1'b0;
            ACTIVE   <= 1'b0;
            CLK_out  <= 1'b0;
            PULSE    <= 1'b0;
        end else begin
            ACK <= accept;
            if (accept) begin
                quo     <= NUM;
                den_s   <= DEN;
                rem     <= '0;
                div_cnt <= '0;
                CFG_ERR <= 1'b0;
            end else if (div_step) begin
                quo     <= {quo[WIDTH-2:0], rem_ge};
                rem     <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                div_cnt <= div_cnt + CW'(1);
            end
            if (cfg_bad) CFG_ERR <= 1'b1;
            if (apply_now) begin
                n_live   <= quo;
                x_live   <= rem;
                den_live <= den_s;
                ACTIVE   <= 1'b1;
            end
            if (boundary) begin
                cnt     <= '0;
                per     <= per_nxt;
                acc     <= acc_nxt;
                CLK_out <= 1'b1;
                PULSE   <= 1'b1;
            end else begin
                PULSE <= 1'b0;
                if (ACTIVE && EN) begin
                    cnt     <= cnt + WIDTH'(1);
                    CLK_out <= clk_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_frac_freqdiv_prog.sv
// tb/tb_frac_freqdiv_prog.sv - scoreboard bench for frac_freqdiv_prog
module tb_frac_freqdiv_prog;
    localparam int WIDTH = 8;

    logic             CLK_in = 1'b0;
    logic             RST, EN, LOAD;
    logic [WIDTH-1:0] NUM, DEN;
    logic             ACK, BUSY, CFG_ERR, ACTIVE, CLK_out, PULSE;

    frac_freqdiv_prog #(.WIDTH(WIDTH)) dut (
        .CLK_in(CLK_in), .RST(RST), .EN(EN), .LOAD(LOAD), .NUM(NUM), .DEN(DEN),
        .ACK(ACK), .BUSY(BUSY), .CFG_ERR(CFG_ERR), .ACTIVE(ACTIVE),
        .CLK_out(CLK_out), .PULSE(PULSE)
    );

    always #5 CLK_in = ~CLK_in;

    typedef struct {int p; int h;} per_t;
    per_t sb[$];
    per_t mon_e;
    int   n_checks = 0;
    int   n_errs = 0;
    int   cyc = 0;
    int   mn, mx, md, macc;
    bit   mon_en = 1'b0;
    bit   have_prev = 1'b0;
    int   len = 0;
    int   hi = 0;

    always @(posedge CLK_in) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_in);
        #2;
    endtask

    task automatic set_model(input int num, input int den);
        mn = num / den;
        mx = num % den;
        md = den;
        macc = 0;
    endtask

    task automatic push_model(input int count);
        for (int i = 0; i < count; i++) begin
            int   s;
            per_t e;
            s = macc + mx;
            if (s >= md) begin
                e.p = mn + 1;
                macc = s - md;
            end else begin
                e.p = mn;
                macc = s;
            end
            e.h = e.p / 2;
            sb.push_back(e);
        end
    endtask

    // Measures each output period (in EN=1 counter states) and its high time.
    always @(posedge CLK_in) begin
        #1;
        if (!ACTIVE) begin
            have_prev = 1'b0;
            len = 0;
            hi = 0;
        end else begin
            if (PULSE) begin
                if (have_prev && mon_en) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("period_len", len, mon_e.p);
                        check("period_high", hi, mon_e.h);
                    end
                end
                have_prev = 1'b1;
                len = 0;
                hi = 0;
            end
            if (PULSE || EN) begin
                len++;
                if (CLK_out) hi++;
            end
        end
    end

    task automatic outs_zero(input string tag);
        check({tag, "_ack"}, ACK, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_cfgerr"}, CFG_ERR, 0);
        check({tag, "_active"}, ACTIVE, 0);
        check({tag, "_clk"}, CLK_out, 0);
        check({tag, "_pulse"}, PULSE, 0);
    endtask

    task automatic load_cfg(input int num, input int den, input string tag, output int n);
        NUM = WIDTH'(num);
        DEN = WIDTH'(den);
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        check({tag, "_ack"}, ACK, 1);
        check({tag, "_ack_busy"}, BUSY, 1);
        check({tag, "_ack_cfgerr"}, CFG_ERR, 0);
        n = 0;
        while (BUSY && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check(tag, sb.size(), 0);
        mon_en = 1'b0;
    endtask

    initial begin
        int n, acks, bad, b0, b, k, olds;
        RST = 1'b0; EN = 1'b0; LOAD = 1'b0; NUM = '0; DEN = '0;
        step();
        step();
        outs_zero("rst");
        RST = 1'b1;
        step();
        outs_zero("post_rst");

        // 7/2: periods 3,4,3,4 with high 1,2
        EN = 1'b1;
        set_model(7, 2);
        push_model(20);
        mon_en = 1'b1;
        load_cfg(7, 2, "l72", n);
        check("l72_lat", n, 9);
        check("l72_pulse", PULSE, 1);
        check("l72_clk", CLK_out, 1);
        check("l72_active", ACTIVE, 1);

        load_cfg(50, 0, "den0", n);
        check("den0_lat", n, 9);
        check("den0_err", CFG_ERR, 1);
        check("den0_active", ACTIVE, 1);

        load_cfg(3, 2, "n1", n);
        check("n1_err", CFG_ERR, 1);

        // LOAD held high throughout BUSY; later NUM/DEN values must be ignored
        acks = 0;
        NUM = 8'd255; DEN = 8'd128; LOAD = 1'b1;
        step();
        acks += int'(ACK);
        NUM = 8'd40; DEN = 8'd4;
        n = 0;
        while (BUSY && n < 30) begin
            step();
            acks += int'(ACK);
            n++;
        end
        LOAD = 1'b0;
        check("storm_acks", acks, 1);
        check("storm_lat", n, 9);
        check("storm_err", CFG_ERR, 1);
        drain("a_drain");

        load_cfg(10, 2, "clr", n);
        check("clr_done", BUSY, 0);

        // 10/2: constant period 5, EN pause, then change to 9/3 mid-period
        RST = 1'b0;
        step();
        RST = 1'b1;
        step();
        set_model(10, 2);
        push_model(2);
        mon_en = 1'b1;
        load_cfg(10, 2, "l102", n);
        check("l102_lat", n, 9);
        check("l102_pulse", PULSE, 1);
        EN = 1'b0;
        bad = 0;
        repeat (5) begin
            step();
            if (CLK_out !== 1'b1 || PULSE !== 1'b0) bad++;
        end
        check("pause_hold", bad, 0);
        EN = 1'b1;
        n = 0;
        while (!PULSE && n < 50) begin
            step();
            n++;
        end
        check("pause_resume", n, 5);
        b0 = cyc;
        b = b0;
        while (b < b0 + 1 + 10) b += 5;
        olds = (b - b0) / 5;
        while (sb.size() < olds) push_model(1);
        set_model(9, 3);
        push_model(4);
        NUM = 8'd9; DEN = 8'd3; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        k = cyc;
        check("l93_ack", ACK, 1);
        check("l93_edge", k, b0 + 1);
        n = 0;
        while (BUSY && n < 50) begin
            step();
            n++;
        end
        check("l93_apply_edge", cyc, b);
        check("l93_pulse", PULSE, 1);
        drain("b_drain");

        // Reset during DIVIDE and during a running period
        NUM = 8'd20; DEN = 8'd3; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        step();
        step();
        check("c_busy", BUSY, 1);
        RST = 1'b0;
        #1;
        outs_zero("rst_div");
        step();
        RST = 1'b1;
        step();
        step();
        check("c_active", ACTIVE, 0);
        check("c_clk", CLK_out, 0);
        check("c_idle_busy", BUSY, 0);
        load_cfg(10, 2, "c_l", n);
        check("c_lat", n, 9);
        step();
        check("c_hi", CLK_out, 1);
        RST = 1'b0;
        #1;
        outs_zero("rst_run");
        step();
        RST = 1'b1;
        bad = 0;
        repeat (12) begin
            step();
            if (ACTIVE !== 1'b0 || CLK_out !== 1'b0 || PULSE !== 1'b0) bad++;
        end
        check("c_after_rst", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
